// File: rtl/pp_seq_pkg.sv
// Shared definitions for the parallel-port sequencer.
// Contents: Avalon word addresses of the register map, CTRL/STATUS bit positions
// and the sequencer state type.
package pp_seq_pkg;

   // Register map (Avalon word addresses)
   localparam logic [2:0] ADDR_DIR    = 3'd0;
   localparam logic [2:0] ADDR_PORT   = 3'd1;
   localparam logic [2:0] ADDR_PERIOD = 3'd2;
   localparam logic [2:0] ADDR_FIFO   = 3'd3;
   localparam logic [2:0] ADDR_CTRL   = 3'd4;
   localparam logic [2:0] ADDR_STATUS = 3'd5;
   localparam logic [2:0] ADDR_PIN    = 3'd6;

   // CTRL bits: start/abort are write-only pulses, irq_en is read/write
   localparam int unsigned CTRL_START  = 0;
   localparam int unsigned CTRL_ABORT  = 1;
   localparam int unsigned CTRL_IRQ_EN = 2;

   // STATUS bits: done and ovf are sticky, write 1 to clear
   localparam int unsigned STAT_BUSY  = 0;
   localparam int unsigned STAT_FULL  = 1;
   localparam int unsigned STAT_EMPTY = 2;
   localparam int unsigned STAT_DONE  = 3;
   localparam int unsigned STAT_OVF   = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/pp_seq_fifo.sv
// Synchronous show-ahead FIFO holding the pattern bytes.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   flush         drop all entries (overrides push/pop)
//   push, din     write one entry; accepted when not full or when popping
//   pop           consume the head entry; ignored when empty
//   dout          head entry, valid while !empty
//   level         number of stored entries (0..DEPTH)
//   full, empty   level == DEPTH / level == 0
module pp_seq_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned W     = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic          w_do_push;
   logic          w_do_pop;

   assign w_do_pop  = pop & ~empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign w_do_push = push & (~full | w_do_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_do_push && !w_do_pop)      r_level <= r_level + LW'(1);
         else if (w_do_pop && !w_do_push) r_level <= r_level - LW'(1);
      end
   end

   // Storage needs no reset: entries are only visible once written
   always_ff @(posedge clk) begin
      if (w_do_push && !flush) r_mem[r_wr_ptr] <= din;
   end

   assign dout  = r_mem[r_rd_ptr];
   assign level = r_level;
   assign full  = (r_level == LW'(DEPTH));
   assign empty = (r_level == '0);

endmodule

// File: rtl/parallel_port_sequencer.sv
// Avalon-MM slave for the 8-bit bidirectional parallel port. Owns the pin
// direction/output registers and plays a CPU-loaded byte pattern from a FIFO,
// one byte every max(PERIOD,1) cycles, raising a completion interrupt.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   address, chipselect   Avalon word address / select
//   write, writedata      write strobe and data
//   read, readdata        read strobe, registered read data (1-cycle latency)
//   irq                   level interrupt = done & irq_en (registered)
//   ParPort               parallel-port pins, driven per DIR bit, else Z
module parallel_port_sequencer
   import pp_seq_pkg::*;
#(
   parameter int unsigned PORT_W     = 8,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write,
   input  logic [31:0]       writedata,
   input  logic              read,
   output logic [31:0]       readdata,
   output logic              irq,
   inout  wire  [PORT_W-1:0] ParPort
);

   localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

   logic              w_wr;
   logic              w_rd;
   logic              w_wr_dir;
   logic              w_wr_port;
   logic              w_wr_period;
   logic              w_wr_ctrl;
   logic              w_wr_status;
   logic              w_push;

   logic [PORT_W-1:0] r_dir;
   logic [PORT_W-1:0] r_port;
   logic [31:0]       r_period;
   logic [31:0]       r_cnt;
   logic [31:0]       w_period_eff;
   logic              r_irq_en;
   logic              r_done;
   logic              r_ovf;
   logic              r_irq;
   logic              r_start;
   logic              r_abort;

   state_e            r_state;
   state_e            w_state_next;
   logic              w_busy;
   logic              w_load;
   logic              w_done_set;
   logic              w_flush;

   logic [PORT_W-1:0] w_fifo_dout;
   logic [LW-1:0]     w_level;
   logic              w_full;
   logic              w_empty;

   logic [PORT_W-1:0] r_sync1;
   logic [PORT_W-1:0] r_sync2;
   logic [31:0]       r_readdata;
   logic [31:0]       w_rdata;
   logic [31:0]       w_status;
   logic [31:0]       w_ctrl_rd;

   // Bus decode
   assign w_wr        = chipselect & write;
   assign w_rd        = chipselect & read;
   assign w_wr_dir    = w_wr & (address == ADDR_DIR);
   assign w_wr_port   = w_wr & (address == ADDR_PORT);
   assign w_wr_period = w_wr & (address == ADDR_PERIOD);
   assign w_wr_ctrl   = w_wr & (address == ADDR_CTRL);
   assign w_wr_status = w_wr & (address == ADDR_STATUS);
   assign w_push      = w_wr & (address == ADDR_FIFO);

   assign w_period_eff = (r_period == 32'd0) ? 32'd1 : r_period;

   pp_seq_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (PORT_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (w_flush),
      .push    (w_push),
      .pop     (w_load),
      .din     (writedata[PORT_W-1:0]),
      .dout    (w_fifo_dout),
      .level   (w_level),
      .full    (w_full),
      .empty   (w_empty)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (r_abort) begin
         w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (r_start && !w_empty) w_state_next = RUN;
            RUN:     if ((r_cnt == '0) && w_empty) w_state_next = IDLE;
            default: w_state_next = IDLE;
         endcase
      end
   end

   // Abort beats a start that was registered in the same write
   always_comb begin
      w_busy     = (r_state == RUN);
      w_flush    = r_abort;
      w_load     = 1'b0;
      w_done_set = 1'b0;
      if (!r_abort) begin
         case (r_state)
            IDLE: begin
               w_load     = r_start & ~w_empty;
               w_done_set = r_start & w_empty;
            end
            RUN: begin
               if (r_cnt == '0) begin
                  w_load     = ~w_empty;
                  w_done_set = w_empty;
               end
            end
            default: ;
         endcase
      end
   end

   // Step counter: PERIOD is sampled at every reload
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                          r_cnt <= '0;
      else if (w_flush)                      r_cnt <= '0;
      else if (w_load)                       r_cnt <= w_period_eff - 32'd1;
      else if (w_busy && (r_cnt != '0))      r_cnt <= r_cnt - 32'd1;
   end

   // ------------------------------------------------------- register file
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dir    <= '0;
         r_port   <= '0;
         r_period <= '0;
         r_irq_en <= 1'b0;
         r_done   <= 1'b0;
         r_ovf    <= 1'b0;
         r_irq    <= 1'b0;
         r_start  <= 1'b0;
         r_abort  <= 1'b0;
      end else begin
         if (w_wr_dir)    r_dir    <= writedata[PORT_W-1:0];
         if (w_wr_period) r_period <= writedata;
         if (w_wr_ctrl)   r_irq_en <= writedata[CTRL_IRQ_EN];
         // start/abort act one cycle after the CPU write
         r_start <= w_wr_ctrl & writedata[CTRL_START];
         r_abort <= w_wr_ctrl & writedata[CTRL_ABORT];

         if (w_load)                     r_port <= w_fifo_dout;
         else if (w_wr_port && !w_busy)  r_port <= writedata[PORT_W-1:0];

         // Hardware set wins over a same-cycle W1C
         r_done <= (r_done & ~(w_wr_status & writedata[STAT_DONE])) | w_done_set;
         r_ovf  <= (r_ovf  & ~(w_wr_status & writedata[STAT_OVF]))
                 | (w_push & w_full & ~w_load & ~w_flush);

         r_irq  <= r_done & r_irq_en;
      end
   end

   // Pin input synchronizer
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= ParPort;
         r_sync2 <= r_sync1;
      end
   end

   // ----------------------------------------------------------- read path
   always_comb begin
      w_status             = '0;
      w_status[STAT_BUSY]  = w_busy;
      w_status[STAT_FULL]  = w_full;
      w_status[STAT_EMPTY] = w_empty;
      w_status[STAT_DONE]  = r_done;
      w_status[STAT_OVF]   = r_ovf;
   end

   always_comb begin
      w_ctrl_rd              = '0;
      w_ctrl_rd[CTRL_IRQ_EN] = r_irq_en;
   end

   always_comb begin
      w_rdata = '0;
      case (address)
         ADDR_DIR:    w_rdata = 32'(r_dir);
         ADDR_PORT:   w_rdata = 32'(r_port);
         ADDR_PERIOD: w_rdata = r_period;
         ADDR_FIFO:   w_rdata = 32'(w_level);
         ADDR_CTRL:   w_rdata = w_ctrl_rd;
         ADDR_STATUS: w_rdata = w_status;
         ADDR_PIN:    w_rdata = 32'(r_sync2);
         default:     w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  r_readdata <= '0;
      else if (w_rd) r_readdata <= w_rdata;
   end

   assign readdata = r_readdata;
   assign irq      = r_irq;

   // Tri-state pin drivers
   for (genvar i = 0; i < PORT_W; i++) begin : g_pin
      assign ParPort[i] = r_dir[i] ? r_port[i] : 1'bz;
   end

endmodule

// File: tb/tb_parallel_port_sequencer.sv
// Self-checking bench for parallel_port_sequencer: a timestamp/queue model of the
// register map and sequencer checked every cycle, plus directed literal checks.
module tb_parallel_port_sequencer;
   import pp_seq_pkg::*;

   localparam int unsigned PW    = 8;
   localparam int unsigned DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write;
   logic        read;
   logic [31:0] writedata;
   wire  [31:0] readdata;
   wire         irq;
   wire  [PW-1:0] par_port;

   logic [PW-1:0] ext_val;
   logic [PW-1:0] drv_dir;
   logic          cmp_en;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   parallel_port_sequencer #(
      .PORT_W     (PW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .reset_n    (rst_n),
      .address    (address),
      .chipselect (chipselect),
      .write      (write),
      .writedata  (writedata),
      .read       (read),
      .readdata   (readdata),
      .irq        (irq),
      .ParPort    (par_port)
   );

   // External device drives every pin the DUT is not driving
   for (genvar i = 0; i < PW; i++) begin : g_ext
      assign par_port[i] = drv_dir[i] ? 1'bz : ext_val[i];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ------------------------------------------------------------- model
   logic [PW-1:0] m_dir, m_port, m_pin1, m_pin2, m_pin_now;
   logic [31:0]   m_period, m_rdata, m_p;
   logic          m_irq_en, m_done, m_ovf, m_busy, m_irq, m_irq_nxt;
   logic          m_pend_start, m_pend_abort, m_abort_pre, m_busy_pre;
   logic          m_loaded, m_done_set, mw, mr;
   int            m_end_cyc;
   logic [PW-1:0] m_q [$];

   function automatic logic [31:0] reg_value(input logic [2:0] a);
      logic [31:0] v;
      v = '0;
      case (a)
         3'd0:    v = {24'h0, m_dir};
         3'd1:    v = {24'h0, m_port};
         3'd2:    v = m_period;
         3'd3:    v = 32'(m_q.size());
         3'd4:    v = {29'h0, m_irq_en, 2'b00};
         3'd5:    v = {27'h0, m_ovf, m_done, m_q.size() == 0, m_q.size() == int'(DEPTH), m_busy};
         3'd6:    v = {24'h0, m_pin2};
         default: v = '0;
      endcase
      return v;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_dir = '0; m_port = '0; m_period = '0; m_irq_en = 1'b0;
         m_done = 1'b0; m_ovf = 1'b0; m_busy = 1'b0; m_irq = 1'b0;
         m_rdata = '0; m_pin1 = '0; m_pin2 = '0;
         m_pend_start = 1'b0; m_pend_abort = 1'b0; m_end_cyc = 0;
         m_q.delete();
         drv_dir <= '0;
      end else begin
         cyc++;
         mw = chipselect & write;
         mr = chipselect & read;
         m_pin_now = (m_dir & m_port) | (~m_dir & ext_val);
         m_irq_nxt = m_done & m_irq_en;
         if (mr) m_rdata = reg_value(address);
         m_busy_pre  = m_busy;
         m_abort_pre = m_pend_abort;
         m_loaded    = 1'b0;
         m_done_set  = 1'b0;
         m_p = (m_period == 32'd0) ? 32'd1 : m_period;
         // Each byte stays on the port until its expiry timestamp
         if (m_pend_abort) begin
            m_q.delete();
            m_busy = 1'b0;
         end else if (m_pend_start && !m_busy) begin
            if (m_q.size() != 0) begin
               m_port = m_q.pop_front(); m_loaded = 1'b1; m_busy = 1'b1;
               m_end_cyc = cyc + int'(m_p);
            end else begin
               m_done_set = 1'b1;
            end
         end else if (m_busy && cyc == m_end_cyc) begin
            if (m_q.size() != 0) begin
               m_port = m_q.pop_front(); m_loaded = 1'b1;
               m_end_cyc = cyc + int'(m_p);
            end else begin
               m_busy = 1'b0; m_done_set = 1'b1;
            end
         end
         m_pend_start = mw && address == ADDR_CTRL && writedata[0];
         m_pend_abort = mw && address == ADDR_CTRL && writedata[1];
         if (mw) begin
            case (address)
               3'd0: m_dir = writedata[7:0];
               3'd1: if (!m_busy_pre && !m_loaded) m_port = writedata[7:0];
               3'd2: m_period = writedata;
               3'd3: if (!m_abort_pre) begin
                  if (m_q.size() < int'(DEPTH)) m_q.push_back(writedata[7:0]);
                  else m_ovf = 1'b1;
               end
               3'd4: m_irq_en = writedata[2];
               3'd5: if (writedata[4]) m_ovf = 1'b0;
               default: ;
            endcase
         end
         m_done = (m_done && !(mw && address == ADDR_STATUS && writedata[3])) || m_done_set;
         m_irq  = m_irq_nxt;
         m_pin2 = m_pin1;
         m_pin1 = m_pin_now;
         drv_dir <= m_dir;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (rst_n && cmp_en) begin
         check("pins", 32'(par_port), 32'((m_dir & m_port) | (~m_dir & ext_val)));
         check("irq", 32'(irq), 32'(m_irq));
         check("readdata", readdata, m_rdata);
      end
   end

   // ------------------------------------------------------------ stimulus
   // All tasks start and end just after a falling edge
   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
      @(negedge clk);
      #1;
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
      address = a; chipselect = 1'b1; read = 1'b1;
      @(negedge clk);
      d = readdata;
      #1;
      chipselect = 1'b0; read = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bus_rd(a, d);
      check(name, d, exp);
   endtask

   logic [7:0] exp_a [10];
   logic [7:0] exp_b [5];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      address = '0; writedata = '0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
      ext_val = 8'h3C; rst_n = 1'b0; cmp_en = 1'b0;
      exp_a = '{8'hA5, 8'hA5, 8'hA5, 8'h5A, 8'h5A, 8'h5A, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b1; cmp_en = 1'b1;

      // Reset state
      check("rst_pins_undriven", 32'(par_port), 32'h3C);
      check("rst_irq", 32'(irq), 32'h0);
      rd_chk("rst_dir", ADDR_DIR, 32'h0);
      rd_chk("rst_port", ADDR_PORT, 32'h0);
      rd_chk("rst_period", ADDR_PERIOD, 32'h0);
      rd_chk("rst_level", ADDR_FIFO, 32'h0);
      rd_chk("rst_ctrl", ADDR_CTRL, 32'h0);
      rd_chk("rst_status", ADDR_STATUS, 32'h04);
      rd_chk("rst_reg7", 3'd7, 32'h0);
      rd_chk("rst_pin", ADDR_PIN, 32'h3C);

      // PERIOD=3, three bytes
      bus_wr(ADDR_DIR, 32'hFF);
      bus_wr(ADDR_PERIOD, 32'd3);
      bus_wr(ADDR_FIFO, 32'hA5);
      bus_wr(ADDR_FIFO, 32'h5A);
      bus_wr(ADDR_FIFO, 32'hFF);
      bus_wr(ADDR_CTRL, 32'h1);
      check("p3_before_load", 32'(par_port), 32'h00);
      for (int k = 0; k < 10; k++) begin
         tick(1);
         check("p3_timeline", 32'(par_port), 32'(exp_a[k]));
      end
      rd_chk("p3_status", ADDR_STATUS, 32'h0C);
      rd_chk("p3_port", ADDR_PORT, 32'hFF);

      // PERIOD=0: one byte per cycle
      bus_wr(ADDR_STATUS, 32'h08);
      bus_wr(ADDR_PERIOD, 32'd0);
      bus_wr(ADDR_FIFO, 32'h11);
      bus_wr(ADDR_FIFO, 32'h22);
      bus_wr(ADDR_FIFO, 32'h33);
      bus_wr(ADDR_FIFO, 32'h44);
      bus_wr(ADDR_CTRL, 32'h1);
      for (int k = 0; k < 5; k++) begin
         tick(1);
         check("p0_timeline", 32'(par_port), 32'(exp_b[k]));
      end
      rd_chk("p0_status", ADDR_STATUS, 32'h0C);

      // Overflow: 17 pushes into 16 entries
      bus_wr(ADDR_STATUS, 32'h08);
      for (int i = 0; i < 17; i++) bus_wr(ADDR_FIFO, 32'(8'h80 + i));
      rd_chk("ovf_level", ADDR_FIFO, 32'd16);
      rd_chk("ovf_status", ADDR_STATUS, 32'h12);
      bus_wr(ADDR_STATUS, 32'h10);
      rd_chk("ovf_w1c", ADDR_STATUS, 32'h02);
      bus_wr(ADDR_CTRL, 32'h1);
      tick(17);
      rd_chk("ovf_last_byte", ADDR_PORT, 32'h8F);
      rd_chk("ovf_done", ADDR_STATUS, 32'h0C);

      // Abort mid-sequence
      bus_wr(ADDR_STATUS, 32'h08);
      bus_wr(ADDR_PERIOD, 32'd4);
      for (int i = 1; i <= 5; i++) bus_wr(ADDR_FIFO, 32'(i));
      bus_wr(ADDR_CTRL, 32'h1);
      tick(6);
      bus_wr(ADDR_CTRL, 32'h2);
      tick(1);
      rd_chk("abort_status", ADDR_STATUS, 32'h04);
      rd_chk("abort_level", ADDR_FIFO, 32'h0);
      rd_chk("abort_port", ADDR_PORT, 32'h02);
      check("abort_pins", 32'(par_port), 32'h02);

      // Start with empty FIFO and irq enabled
      bus_wr(ADDR_CTRL, 32'h5);
      tick(2);
      check("empty_start_irq", 32'(irq), 32'h1);
      rd_chk("empty_start_status", ADDR_STATUS, 32'h0C);
      rd_chk("ctrl_readback", ADDR_CTRL, 32'h04);

      // Mixed direction and pin synchronizer
      bus_wr(ADDR_STATUS, 32'h08);
      bus_wr(ADDR_DIR, 32'h0F);
      bus_wr(ADDR_PORT, 32'h05);
      ext_val = 8'hA0;
      tick(2);
      check("mixed_pins", 32'(par_port), 32'hA5);
      rd_chk("pin_sync", ADDR_PIN, 32'hA5);

      // PORT write ignored while busy
      bus_wr(ADDR_PERIOD, 32'd10);
      bus_wr(ADDR_FIFO, 32'h77);
      bus_wr(ADDR_CTRL, 32'h1);
      tick(2);
      bus_wr(ADDR_PORT, 32'h33);
      rd_chk("port_wr_busy", ADDR_PORT, 32'h77);
      bus_wr(ADDR_CTRL, 32'h2);
      tick(2);

      // Asynchronous reset in the middle of a run
      bus_wr(ADDR_DIR, 32'hFF);
      bus_wr(ADDR_PERIOD, 32'd5);
      bus_wr(ADDR_FIFO, 32'hC1);
      bus_wr(ADDR_FIFO, 32'hC2);
      bus_wr(ADDR_CTRL, 32'h1);
      tick(3);
      check("pre_reset_pins", 32'(par_port), 32'hC1);
      rst_n = 1'b0;
      #1;
      check("async_rst_port", 32'(dut.r_port), 32'h0);
      check("async_rst_busy", 32'(dut.r_state == RUN), 32'h0);
      check("async_rst_readdata", readdata, 32'h0);
      check("async_rst_pins", 32'(par_port), 32'(ext_val));
      tick(2);
      rst_n = 1'b1;
      tick(1);
      rd_chk("post_rst_status", ADDR_STATUS, 32'h04);
      rd_chk("post_rst_port", ADDR_PORT, 32'h0);
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/parallel_port_sequencer.md
Name: parallel_port_sequencer

Overview:
Avalon-MM slave controller for the 8-bit bidirectional parallel-port conduit in the Nios II soc_system. It owns the pin direction and output registers. It also plays back a CPU-loaded byte pattern on the port, one byte per programmable number of clock cycles, from an internal FIFO. This gives the software precise, jitter-free sequences. A completion interrupt goes to the Nios II.

Parameters:
PORT_W, 8, parallel-port pin count (width of DIR/PORT/pattern bytes)
FIFO_DEPTH, 16, pattern FIFO entries; power of 2, >=2

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
address  in  3  Avalon word address
chipselect  in  1  Avalon select
write  in  1  write strobe
writedata  in  32  write data
read  in  1  read strobe
readdata  out  32  read data, registered, 1-cycle read latency
irq  out  1  level interrupt
ParPort  inout  PORT_W  parallel-port pins

Behaviour:
- Interface: one clock (clk); reset_n is asynchronous, active-low. All flops clear immediately on reset_n=0, including mid-sequence.
- Reset values:
  - DIR=0, so all pins are Z.
  - port_q=0, PERIOD=0, CTRL.irq_en=0.
  - FIFO empty, state IDLE, done=0, ovf=0.
  - readdata=0, irq=0.
- Register map (word address, R/W):
  - 0 DIR RW: bit i=1 drives pin i.
  - 1 PORT RW: port_q. Writes are ignored while busy. Reads always return the current port_q.
  - 2 PERIOD RW 32b: step length P'=max(PERIOD,1) cycles.
  - 3 FIFO: write pushes writedata[PORT_W-1:0]. Read returns the fill level (0..FIFO_DEPTH).
  - 4 CTRL: write-only bits are bit0 start and bit1 abort. bit2 irq_en is RW. Reads return {irq_en,2'b0}.
  - 5 STATUS: bit0 busy, bit1 full, bit2 empty, bit3 done (sticky), bit4 ovf (sticky). Writing 1 to bit3/bit4 clears it.
  - 6 PIN R: ParPort through a 2-flop synchronizer.
  - 7: reads 0, writes ignored.
- Pin drive: ParPort[i] = DIR[i] ? port_q[i] : Z.
- State machine IDLE/RUN, with a 32-bit down-counter cnt:
  - IDLE, start=1, FIFO non-empty: pop into port_q at the next edge, cnt<=P'-1, go to RUN.
  - IDLE, start=1, FIFO empty: done<=1, stay IDLE.
  - RUN, cnt!=0: cnt<=cnt-1.
  - RUN, cnt==0, FIFO non-empty: pop into port_q, cnt<=P'-1. Steps are back-to-back with no gap.
  - RUN, cnt==0, FIFO empty: go to IDLE, done<=1. port_q keeps the last byte.
  - start while RUN: ignored.
  - abort: flush FIFO, go to IDLE, port_q keeps its current value, done unchanged. Abort wins over a simultaneous start.
- Timing: start written at edge T puts byte0 in port_q at edge T+1. Each byte is held exactly P' cycles. busy=1 from T+1 to the edge where IDLE is re-entered.
- PERIOD is sampled at each reload. A change mid-sequence affects the next byte.
- FIFO push when full: data dropped, ovf<=1. The exception is a same-cycle pop, where the push is accepted. Push and pop in the same cycle leave the level unchanged.
- Same-cycle W1C of done and a hardware set of done: the set wins.
- irq = done & irq_en, registered.
- readdata updates one cycle after read&chipselect. Otherwise it holds its value.

Decomposition:
- Package pp_seq_pkg holds:
  - register address localparams (ADDR_DIR..ADDR_PIN)
  - CTRL/STATUS bit indices
  - state enum {IDLE, RUN}
- Sub-module pp_seq_fifo is a synchronous FIFO with these ports: push, pop, din, dout (show-ahead), level, full, empty. Its parameters are DEPTH and W.
- The top holds:
  - the register file
  - the FSM and counter
  - the synchronizer
  - the tri-state drivers

Test Plan:
- Reset, then read all registers: DIR=0, PORT=0, STATUS=0x04 (empty), ParPort=Z, irq=0. Assert reset_n mid-RUN: port_q=0 and busy=0 immediately.
- DIR=0xFF, PERIOD=3, push 0xA5,0x5A,0xFF, start. ParPort shows A5 for 3 cycles, then 5A for 3, then FF for 3. busy drops and done=1. ParPort stays FF. PORT reads 0xFF.
- PERIOD=0, push 4 bytes, start: a new byte appears every cycle and the sequence completes in 4 cycles.
- Push 17 bytes with FIFO_DEPTH=16: level=16, ovf=1, the 17th byte is discarded. W1C bit4 gives ovf=0.
- Mid-sequence abort with 5 bytes queued: busy=0 next cycle, level=0, port_q holds the current byte, done stays 0. Start with an empty FIFO: done=1 immediately, irq=1 when irq_en=1.
- DIR=0x0F with an external drive of 0xA0 on pins [7:4]. PIN read reflects 0xA0 in the upper nibble 2 cycles after the drive. A PORT write while busy leaves port_q unchanged.
